// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
// Package : sweep_pkg
// Shared state encodings and sizing for the system_sweep truth-table sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package sweep_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] FINISH  = 2'd3;

  localparam int NUM_VECTORS = 16;
  localparam int VEC_W       = 4;

endpackage
`default_nettype wire

// File: rtl/system_sweep_if.sv
`default_nettype none
// ============================================================================
// Interface : system_sweep_if
// Control, vector drive and result signals between the sequencer and the
// gate network / host. "truth_table" carries the captured table.
// Revision  : 1.0 - initial release
// ============================================================================
interface system_sweep_if;
  import sweep_pkg::*;

  logic                   start;
  logic                   va;
  logic                   vb;
  logic                   vc;
  logic                   vd;
  logic                   outa;
  logic [NUM_VECTORS-1:0] expected;
  logic                   busy;
  logic                   done;
  logic [NUM_VECTORS-1:0] truth_table;
  logic                   match;

  modport master (
    input  start, outa, expected,
    output va, vb, vc, vd, busy, done, truth_table, match
  );

  modport slave (
    output start, outa, expected,
    input  va, vb, vc, vd, busy, done, truth_table, match
  );

endinterface
`default_nettype wire

// File: rtl/sweep_timer.sv
`default_nettype none
// ============================================================================
// Module  : sweep_timer
// 8-bit loadable down-counter that stops at zero and flags it.
// Revision: 1.0 - initial release
// ============================================================================
module sweep_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign zero = (r_count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/system_sweep.sv
`default_nettype none
// ============================================================================
// Module  : system_sweep
// Walks a 4-input network through all 16 vectors, captures its response into
// a truth table and compares the result against a golden table.
// Revision: 1.0 - initial release
// ============================================================================
module system_sweep
  import sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  system_sweep_if.master       bus
);

  localparam logic [7:0] c_reload = 8'(SETTLE_CYCLES - 1);

  logic [1:0]             r_state;
  logic [VEC_W-1:0]       r_vec;
  logic [VEC_W-1:0]       r_drive;
  logic [NUM_VECTORS-1:0] r_table;
  logic                   r_match;
  logic [NUM_VECTORS-1:0] w_table_next;
  logic                   w_last;
  logic                   w_load;
  logic                   w_zero;

  assign w_last = (r_vec == VEC_W'(NUM_VECTORS - 1));

  // The compare on the final capture must see the bit being written this edge.
  always_comb begin
    w_table_next        = r_table;
    w_table_next[r_vec] = bus.outa;
  end

  assign w_load = ((r_state == IDLE) && bus.start) ||
                  ((r_state == CAPTURE) && !w_last);

  sweep_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (c_reload),
    .zero     (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_drive <= '0;
      r_table <= '0;
      r_match <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= SETTLE;
            r_vec   <= '0;
            r_drive <= '0;
            r_table <= '0;
            r_match <= 1'b0;
          end
        end
        SETTLE: begin
          if (w_zero) begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_table <= w_table_next;
          if (w_last) begin
            r_match <= (w_table_next == bus.expected);
            r_drive <= '0;
            r_state <= FINISH;
          end else begin
            r_vec   <= r_vec + VEC_W'(1);
            r_drive <= r_vec + VEC_W'(1);
            r_state <= SETTLE;
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign {bus.va, bus.vb, bus.vc, bus.vd} = r_drive;
  assign bus.busy        = (r_state == SETTLE) || (r_state == CAPTURE);
  assign bus.done        = (r_state == FINISH);
  assign bus.truth_table = r_table;
  assign bus.match       = r_match;

endmodule
`default_nettype wire

// File: tb/tb_system_sweep.sv
`default_nettype none
// ============================================================================
// Module  : tb_system_sweep
// Self-checking bench: two sequencers (S=2 and S=1) sweep modelled networks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_system_sweep;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  system_sweep_if sb2 ();
  system_sweep_if sb1 ();

  system_sweep #(.SETTLE_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(sb2));
  system_sweep #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(sb1));

  int          mode2 = 0;
  int          mode1 = 0;
  logic [15:0] rnd_tt = 16'h0;
  int          checks = 0;
  int          errors = 0;

  // Network models: 0 loopback of vd, 1 4-input NAND, 2 buffer of va, else lookup.
  function automatic logic net(input int m, input logic [3:0] v, input logic [15:0] rt);
    case (m)
      0:       return v[0];
      1:       return ~&v;
      2:       return v[3];
      default: return rt[v];
    endcase
  endfunction

  function automatic logic [15:0] ref_table(input int m, input logic [15:0] rt);
    logic [15:0] t;
    t = 16'h0;
    for (int i = 0; i < 16; i++) t[i] = net(m, 4'(i), rt);
    return t;
  endfunction

  assign sb2.outa = net(mode2, {sb2.va, sb2.vb, sb2.vc, sb2.vd}, rnd_tt);
  assign sb1.outa = net(mode1, {sb1.va, sb1.vb, sb1.vc, sb1.vd}, rnd_tt);

  // One full sweep on the S=2 instance, optionally poking start while busy.
  task automatic run_sweep(input int m, input logic [15:0] exp, input bit poke, input string name);
    int          cnt;
    int          bad;
    logic [15:0] rt;
    mode2        = m;
    sb2.expected = exp;
    rt           = ref_table(m, rnd_tt);
    @(negedge clk);
    sb2.start = 1'b1;
    @(negedge clk);
    sb2.start = 1'b0;
    cnt = 1;
    checks++;
    if (sb2.truth_table !== 16'h0 || sb2.match !== 1'b0 || sb2.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_start_state: table=%h match=%b busy=%b, want table=0000 match=0 busy=1",
               name, sb2.truth_table, sb2.match, sb2.busy);
    end
    bad = 0;
    while (sb2.done !== 1'b1 && cnt < 200) begin
      if ({sb2.va, sb2.vb, sb2.vc, sb2.vd} !== 4'((cnt - 1) / 3) || sb2.busy !== 1'b1) bad++;
      sb2.start = (poke && (cnt == 10 || cnt == 30)) ? 1'b1 : 1'b0;
      @(negedge clk);
      cnt++;
    end
    sb2.start = 1'b0;
    checks++;
    if (cnt - 1 !== 48) begin
      errors++;
      $display("FAIL %s_done_latency: got %0d cycles, want 48", name, cnt - 1);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_vector_drive: %0d bad cycles, want 0", name, bad);
    end
    checks++;
    if (sb2.truth_table !== rt) begin
      errors++;
      $display("FAIL %s_table: got %h, want %h", name, sb2.truth_table, rt);
    end
    checks++;
    if (sb2.match !== (rt == exp)) begin
      errors++;
      $display("FAIL %s_match: got %b, want %b", name, sb2.match, (rt == exp));
    end
    checks++;
    if (sb2.busy !== 1'b0 || {sb2.va, sb2.vb, sb2.vc, sb2.vd} !== 4'h0) begin
      errors++;
      $display("FAIL %s_finish_idle: busy=%b vec=%b, want busy=0 vec=0000",
               name, sb2.busy, {sb2.va, sb2.vb, sb2.vc, sb2.vd});
    end
    @(negedge clk);
    checks++;
    if (sb2.done !== 1'b0 || sb2.truth_table !== rt) begin
      errors++;
      $display("FAIL %s_single_done: done=%b table=%h, want done=0 table=%h",
               name, sb2.done, sb2.truth_table, rt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sb2.start = 1'b0; sb2.expected = 16'h0;
    sb1.start = 1'b0; sb1.expected = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({sb2.va, sb2.vb, sb2.vc, sb2.vd, sb2.busy, sb2.done, sb2.match} !== 7'b0 ||
        sb2.truth_table !== 16'h0) begin
      errors++;
      $display("FAIL reset_s2: outs=%b table=%h, want all 0",
               {sb2.va, sb2.vb, sb2.vc, sb2.vd, sb2.busy, sb2.done, sb2.match}, sb2.truth_table);
    end
    checks++;
    if ({sb1.va, sb1.vb, sb1.vc, sb1.vd, sb1.busy, sb1.done, sb1.match} !== 7'b0 ||
        sb1.truth_table !== 16'h0) begin
      errors++;
      $display("FAIL reset_s1: outs=%b table=%h, want all 0",
               {sb1.va, sb1.vb, sb1.vc, sb1.vd, sb1.busy, sb1.done, sb1.match}, sb1.truth_table);
    end
  endtask

  task automatic test_directed();
    run_sweep(0, 16'hAAAA, 1'b0, "loopback");
    run_sweep(1, 16'h7FFF, 1'b0, "nand4");
    run_sweep(2, 16'h00FF, 1'b0, "mismatch");
  endtask

  task automatic test_random();
    logic [15:0] exp;
    for (int n = 0; n < 4; n++) begin
      rnd_tt = 16'($urandom);
      exp    = ($urandom_range(0, 1) == 1) ? rnd_tt : 16'($urandom);
      run_sweep(3, exp, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid_sweep();
    int dones;
    mode2 = 0;
    sb2.expected = 16'hAAAA;
    @(negedge clk);
    sb2.start = 1'b1;
    @(negedge clk);
    sb2.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({sb2.va, sb2.vb, sb2.vc, sb2.vd, sb2.busy, sb2.done, sb2.match} !== 7'b0 ||
        sb2.truth_table !== 16'h0) begin
      errors++;
      $display("FAIL midreset_outputs: outs=%b table=%h, want all 0",
               {sb2.va, sb2.vb, sb2.vc, sb2.vd, sb2.busy, sb2.done, sb2.match}, sb2.truth_table);
    end
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (sb2.done !== 1'b0) dones++;
    end
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (sb2.done !== 1'b0) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: saw %0d done cycles, want 0", dones);
    end
    run_sweep(0, 16'hAAAA, 1'b0, "after_reset");
  endtask

  task automatic test_start_while_busy();
    run_sweep(1, 16'h7FFF, 1'b1, "busy_poke");
  endtask

  task automatic test_start_held();
    int times[3];
    int nd;
    int cnt;
    mode1 = 0;
    sb1.expected = 16'hAAAA;
    @(negedge clk);
    sb1.start = 1'b1;
    nd  = 0;
    cnt = 0;
    while (nd < 3 && cnt < 300) begin
      @(negedge clk);
      cnt++;
      if (sb1.done === 1'b1) begin
        times[nd] = cnt;
        nd++;
        checks++;
        if (sb1.truth_table !== 16'hAAAA || sb1.match !== 1'b1) begin
          errors++;
          $display("FAIL held_table_at_done: table=%h match=%b, want table=aaaa match=1",
                   sb1.truth_table, sb1.match);
        end
      end
    end
    sb1.start = 1'b0;
    checks++;
    if (nd !== 3) begin
      errors++;
      $display("FAIL held_done_count: got %0d pulses, want 3", nd);
    end else begin
      checks++;
      if (times[0] - 1 !== 32) begin
        errors++;
        $display("FAIL held_first_latency: got %0d, want 32", times[0] - 1);
      end
      checks++;
      if (times[1] - times[0] !== 34 || times[2] - times[1] !== 34) begin
        errors++;
        $display("FAIL held_spacing: got %0d and %0d, want 34 and 34",
                 times[1] - times[0], times[2] - times[1]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_sweep();
    test_start_while_busy();
    test_start_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/system_sweep.md
# system_sweep

Stimulus/response sequencer for four-input, single-output gate networks. It drives `va`, `vb`, `vc` and `vd` through all 16 input combinations in ascending order. For each combination it waits a programmable settle time, then samples the network's `outa`. At the end of the sweep it presents the 16-bit truth table and a pass/fail compare against an expected table. It sits on the opposite side of the network's ports: outputs where the network has inputs, and an input where the network has its output.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each vector is held before its capture cycle. Legal range is 1..255.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: sweep request, sampled only in IDLE.
- `va` output 1: vector bit 3.
- `vb` output 1: vector bit 2.
- `vc` output 1: vector bit 1.
- `vd` output 1: vector bit 0.
- `outa` input 1: response of the network under test.
- `expected` input 16: golden truth table, sampled on the final capture edge.
- `busy` output 1: high while in SETTLE or CAPTURE.
- `done` output 1: one-cycle pulse at sweep end.
- `table` output 16: bit i = `outa` captured for vector i, where i = {va,vb,vc,vd}.
- `match` output 1: (`table` == `expected`), valid from `done` onward.

## Operation
- The FSM has four states: IDLE, SETTLE, CAPTURE and FINISH.
- IDLE:
  - If `start`=1: load vec=0, clear `table`, clear `match`, load the settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - Drive `{va,vb,vc,vd}`=vec.
  - If counter=0, go to CAPTURE; otherwise decrement the counter.
- CAPTURE:
  - On the exit edge, `table[vec]` <= `outa`.
  - If vec=15: register `match` using the updated table and the current `expected`, then go to FINISH.
  - Otherwise: vec <= vec+1, reload the counter, go to SETTLE.
- FINISH:
  - `done`=1 for this single cycle, then go to IDLE.
- Vector drive outputs:
  - They are registered and equal vec while `busy`.
  - In IDLE and FINISH all four are 0.
- vec is a 4-bit counter and never wraps during a sweep, because the 15→FINISH transition takes priority.
- `table` and `match` hold their values after `done` until the next accepted `start` or reset.
- `start` is ignored in SETTLE, CAPTURE and FINISH; there is no queuing.
- If `start` is held high continuously, a new sweep begins the cycle after FINISH (IDLE accepts it at once).
- Reset value of every output is 0: `va`..`vd`, `busy`, `done`, `table`, `match`. The FSM resets to IDLE, vec=0 and counter=0.
- Reset asserted mid-sweep aborts immediately: outputs return to reset values and no partial `done` is produced.

## Timing
- Let `start` be accepted at edge k.
- Vector i is driven from edge k+i·(S+1), where S = SETTLE_CYCLES.
- Vector i is captured at edge k+i·(S+1)+S+1.
- `done` is high in the cycle following edge k+16·(S+1). For S=2 that is edge k+48.
- `busy` rises at edge k and falls at edge k+16·(S+1).
- `outa` is sampled at the end of each CAPTURE cycle, so the network has at least S+1 cycles of propagation from the vector change.
- Minimum period between `done` pulses, with `start` tied high, is 16·(S+1)+2 cycles.

## Structure
- Shared package (`sweep_pkg`) holds:
  - state encodings: IDLE=2'd0, SETTLE=2'd1, CAPTURE=2'd2, FINISH=2'd3;
  - `NUM_VECTORS`=16;
  - `VEC_W`=4.
- Sub-module `sweep_timer`: an 8-bit down-counter with `load`, `load_val` and a `zero` flag, plus the same asynchronous reset. `system_sweep` instantiates it once for the settle count.
- The top level contains the FSM, the vec counter, the table register and the compare.

## Test plan
- `outa` looped to `vd`, S=2, `start` pulsed:
  - `table`=16'hAAAA;
  - with `expected`=16'hAAAA, `match`=1;
  - `done` exactly 48 cycles after the start edge.
- Network `outa`=~(va&vb&vc&vd), `expected`=16'h7FFF: `table`=16'h7FFF, `match`=1.
- Network `outa`=va, `expected`=16'h00FF: `table`=16'hFF00, `match`=0, `done` still pulses once.
- `rst` asserted at cycle 20 of a sweep:
  - all outputs 0 immediately, no `done`;
  - a subsequent `start` produces a full, correct sweep.
- `start` held high for 3 sweeps, S=1: `done` pulses spaced 34 cycles apart, and `table` is stable during each `done`.
- `start` pulsed while `busy`: no effect, and sweep timing is unchanged.
